// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the pet controllers: the activity codes exchanged
// between the behaviour FSM and the attribute controller, the attribute
// width and the default thresholds.
package tamagotchi_pkg;

  localparam int LARGURA_ATRIB        = 8;
  localparam int MAX_ATRIBUTO_PADRAO  = 100;
  localparam int LIMIAR_ALERTA_PADRAO = 25;

  typedef enum logic [2:0] {
    OCIOSO     = 3'b000,
    DORMINDO   = 3'b001,
    COMENDO    = 3'b010,
    DANDO_AULA = 3'b011,
    MORTO      = 3'b100
  } estado_t;

  // True for the three timed activity codes.
  function automatic logic eh_atividade(input estado_t e);
    return (e == DORMINDO) || (e == COMENDO) || (e == DANDO_AULA);
  endfunction

endpackage

// File: rtl/controlador_estados_if.sv
// Bundle of the player buttons, the attribute controller feedback and the
// activity/alert outputs of the behaviour FSM.
// master: the side that drives buttons and attributes (bench / system).
// slave:  the behaviour FSM itself.
interface controlador_estados_if;
  import tamagotchi_pkg::*;

  logic                     btn_dormir;
  logic                     btn_comer;
  logic                     btn_aula;
  logic [LARGURA_ATRIB-1:0] fome;
  logic [LARGURA_ATRIB-1:0] sono;
  logic [LARGURA_ATRIB-1:0] felicidade;
  logic                     morreu;
  logic [2:0]               estado;
  logic                     ocupado;
  logic [2:0]               alerta;

  modport master (
    output btn_dormir, btn_comer, btn_aula, fome, sono, felicidade, morreu,
    input  estado, ocupado, alerta
  );

  modport slave (
    input  btn_dormir, btn_comer, btn_aula, fome, sono, felicidade, morreu,
    output estado, ocupado, alerta
  );

endinterface

// File: rtl/controlador_estados_detector_borda.sv
// N-bit rising-edge detector: one-cycle pulse on the first cycle a level
// input is seen high. A held input produces a single pulse.
module detector_borda #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_sinal,
  output logic [N-1:0] o_borda
);

  logic [N-1:0] r_sinal_q;

  // Previous-cycle copy of the inputs, cleared on reset so a level already
  // high at release counts as a new press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sinal_q <= '0;
    else        r_sinal_q <= i_sinal;
  end

  assign o_borda = i_sinal & ~r_sinal_q;

endmodule

// File: rtl/controlador_estados.sv
// Pet behaviour FSM. Turns button presses into timed activities, ends them on
// attribute saturation, timeout or cancel, enforces a cooldown between
// activities, latches a dead state and raises low-attribute alerts.
// Optional build macro CONTROLADOR_AUTO_SONO_EN: when defined, an idle pet
// with low sono and no pending press falls asleep on its own.
module controlador_estados
  import tamagotchi_pkg::*;
#(
  parameter int MAX_ATRIBUTO  = MAX_ATRIBUTO_PADRAO,
  parameter int DURACAO_MAX   = 1000,
  parameter int COOLDOWN      = 50,
  parameter int LIMIAR_ALERTA = LIMIAR_ALERTA_PADRAO
) (
  input logic                 clk,
  input logic                 rst_n,
  controlador_estados_if.slave bus
);

  localparam logic [LARGURA_ATRIB-1:0] L_MAX     = LARGURA_ATRIB'(MAX_ATRIBUTO);
  localparam logic [LARGURA_ATRIB-1:0] L_LIMIAR  = LARGURA_ATRIB'(LIMIAR_ALERTA);
  localparam logic [15:0]              L_TIMEOUT = 16'(DURACAO_MAX - 1);
  localparam logic [15:0]              L_COOL    = 16'(COOLDOWN);

  estado_t                  r_estado;
  logic                     r_ocupado;
  logic [2:0]               r_alerta;
  logic [15:0]              r_timer;
  logic [15:0]              r_cooldown;

  logic [2:0]               w_press;
  logic [2:0]               w_alerta;
  logic [LARGURA_ATRIB-1:0] w_atributo;
  logic                     w_cancel;
  logic                     w_fim;

  // Bit 2 = dormir, bit 1 = comer, bit 0 = aula.
  detector_borda #(.N(3)) u_detector (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_sinal ({bus.btn_dormir, bus.btn_comer, bus.btn_aula}),
    .o_borda (w_press)
  );

  assign w_alerta = {bus.fome < L_LIMIAR, bus.sono < L_LIMIAR, bus.felicidade < L_LIMIAR};

  // Pick the attribute and the cancel button that govern the current activity.
  always_comb begin
    w_atributo = '0;
    w_cancel   = 1'b0;
    case (r_estado)
      DORMINDO:   begin w_atributo = bus.sono;       w_cancel = w_press[2]; end
      COMENDO:    begin w_atributo = bus.fome;       w_cancel = w_press[1]; end
      DANDO_AULA: begin w_atributo = bus.felicidade; w_cancel = w_press[0]; end
      default:    begin w_atributo = '0;             w_cancel = 1'b0;       end
    endcase
  end

  assign w_fim = (w_atributo >= L_MAX) || (r_timer == L_TIMEOUT) || w_cancel;

  // Main FSM with timer, cooldown and registered outputs. Death overrides
  // everything and is only left through reset; alerts freeze once dead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado   <= OCIOSO;
      r_ocupado  <= 1'b0;
      r_alerta   <= 3'b000;
      r_timer    <= '0;
      r_cooldown <= '0;
    end else begin
      if (r_estado != MORTO) r_alerta <= w_alerta;

      if (bus.morreu || (r_estado == MORTO)) begin
        r_estado  <= MORTO;
        r_ocupado <= 1'b0;
      end else begin
        case (r_estado)
          OCIOSO: begin
            if (r_cooldown != '0) begin
              r_cooldown <= r_cooldown - 16'd1;
            end else if (w_press[2]) begin
              r_estado  <= DORMINDO;
              r_timer   <= '0;
              r_ocupado <= 1'b1;
            end else if (w_press[1]) begin
              r_estado  <= COMENDO;
              r_timer   <= '0;
              r_ocupado <= 1'b1;
            end else if (w_press[0]) begin
              r_estado  <= DANDO_AULA;
              r_timer   <= '0;
              r_ocupado <= 1'b1;
`ifdef CONTROLADOR_AUTO_SONO_EN
            end else if (bus.sono < L_LIMIAR) begin
              r_estado  <= DORMINDO;
              r_timer   <= '0;
              r_ocupado <= 1'b1;
`endif
            end
          end
          DORMINDO, COMENDO, DANDO_AULA: begin
            if (w_fim) begin
              r_estado   <= OCIOSO;
              r_cooldown <= L_COOL;
              r_ocupado  <= 1'b0;
            end else if (r_timer != 16'hFFFF) begin
              r_timer <= r_timer + 16'd1;
            end
          end
          default: begin
            r_estado  <= OCIOSO;
            r_ocupado <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.estado  = r_estado;
  assign bus.ocupado = r_ocupado;
  assign bus.alerta  = r_alerta;

endmodule

// File: tb/tb_controlador_estados.sv
// Directed bench for controlador_estados with DURACAO_MAX=20, COOLDOWN=4,
// LIMIAR_ALERTA=25, MAX_ATRIBUTO=100. Honours CONTROLADOR_AUTO_SONO_EN.
module tb_controlador_estados;

  logic clk;
  logic rst_n;
  int   numChecks;
  int   numFails;

  controlador_estados_if bus_if();

  controlador_estados #(
    .MAX_ATRIBUTO  (100),
    .DURACAO_MAX   (20),
    .COOLDOWN      (4),
    .LIMIAR_ALERTA (25)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle 1 ns past it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive buttons and attributes.
  task automatic applyStimulus(input logic [2:0] btns, input logic [7:0] f,
                               input logic [7:0] s, input logic [7:0] h,
                               input logic m);
    bus_if.btn_dormir = btns[2];
    bus_if.btn_comer  = btns[1];
    bus_if.btn_aula   = btns[0];
    bus_if.fome       = f;
    bus_if.sono       = s;
    bus_if.felicidade = h;
    bus_if.morreu     = m;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    numChecks = 0;
    numFails  = 0;
    rst_n = 1'b0;
    applyStimulus(3'b000, 8'd50, 8'd60, 8'd60, 1'b0);
    tick(2);
    checkOutput("reset_estado", 16'(bus_if.estado), 16'h0);
    checkOutput("reset_ocupado", 16'(bus_if.ocupado), 16'h0);
    checkOutput("reset_alerta", 16'(bus_if.alerta), 16'h0);
    rst_n = 1'b1;
    tick(1);

    // Held btn_comer: one start, no self-cancel while held.
    applyStimulus(3'b010, 8'd50, 8'd60, 8'd60, 1'b0);
    tick(1);
    checkOutput("comer_start", 16'(bus_if.estado), 16'h2);
    checkOutput("comer_ocupado", 16'(bus_if.ocupado), 16'h1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checkOutput("comer_held", 16'(bus_if.estado), 16'h2);
    end
    applyStimulus(3'b001, 8'd50, 8'd60, 8'd60, 1'b0);
    tick(1);
    checkOutput("comer_aula_ignored", 16'(bus_if.estado), 16'h2);
    applyStimulus(3'b000, 8'd100, 8'd60, 8'd60, 1'b0);
    tick(1);
    checkOutput("comer_saturate", 16'(bus_if.estado), 16'h0);
    checkOutput("comer_exit_ocupado", 16'(bus_if.ocupado), 16'h0);
    applyStimulus(3'b000, 8'd50, 8'd60, 8'd60, 1'b0);
    tick(4);

    // DORMINDO timeout after 20 cycles, then cooldown of 4.
    applyStimulus(3'b100, 8'd50, 8'd60, 8'd60, 1'b0);
    tick(1);
    checkOutput("dormir_start", 16'(bus_if.estado), 16'h1);
    applyStimulus(3'b000, 8'd50, 8'd60, 8'd60, 1'b0);
    tick(18);
    checkOutput("dormir_before_timeout", 16'(bus_if.estado), 16'h1);
    tick(1);
    checkOutput("dormir_last_cycle", 16'(bus_if.estado), 16'h1);
    tick(1);
    checkOutput("dormir_timeout", 16'(bus_if.estado), 16'h0);
    applyStimulus(3'b010, 8'd50, 8'd60, 8'd60, 1'b0);
    tick(1);
    checkOutput("cool_1", 16'(bus_if.estado), 16'h0);
    applyStimulus(3'b001, 8'd50, 8'd60, 8'd60, 1'b0);
    tick(1);
    checkOutput("cool_2", 16'(bus_if.estado), 16'h0);
    applyStimulus(3'b010, 8'd50, 8'd60, 8'd60, 1'b0);
    tick(1);
    checkOutput("cool_3", 16'(bus_if.estado), 16'h0);
    applyStimulus(3'b001, 8'd50, 8'd60, 8'd60, 1'b0);
    tick(1);
    checkOutput("cool_4", 16'(bus_if.estado), 16'h0);
    applyStimulus(3'b010, 8'd50, 8'd60, 8'd60, 1'b0);
    tick(1);
    checkOutput("cool_done_accept", 16'(bus_if.estado), 16'h2);
    applyStimulus(3'b000, 8'd120, 8'd60, 8'd60, 1'b0);
    tick(1);
    checkOutput("comer_over100", 16'(bus_if.estado), 16'h0);
    applyStimulus(3'b000, 8'd50, 8'd60, 8'd60, 1'b0);
    tick(4);

    // Simultaneous presses: dormir wins; second dormir press cancels.
    applyStimulus(3'b111, 8'd50, 8'd60, 8'd60, 1'b0);
    tick(1);
    checkOutput("prio_dormir", 16'(bus_if.estado), 16'h1);
    applyStimulus(3'b000, 8'd50, 8'd60, 8'd60, 1'b0);
    tick(1);
    checkOutput("prio_hold", 16'(bus_if.estado), 16'h1);
    applyStimulus(3'b100, 8'd50, 8'd60, 8'd60, 1'b0);
    tick(1);
    checkOutput("dormir_cancel", 16'(bus_if.estado), 16'h0);
    applyStimulus(3'b000, 8'd50, 8'd60, 8'd60, 1'b0);
    tick(4);

    // DANDO_AULA, then death: sticky, alerts frozen, only reset leaves.
    applyStimulus(3'b001, 8'd50, 8'd60, 8'd60, 1'b0);
    tick(1);
    checkOutput("aula_start", 16'(bus_if.estado), 16'h3);
    applyStimulus(3'b000, 8'd50, 8'd60, 8'd60, 1'b1);
    tick(1);
    checkOutput("morto_enter", 16'(bus_if.estado), 16'h4);
    checkOutput("morto_ocupado", 16'(bus_if.ocupado), 16'h0);
    applyStimulus(3'b100, 8'd10, 8'd10, 8'd10, 1'b0);
    tick(2);
    checkOutput("morto_sticky", 16'(bus_if.estado), 16'h4);
    checkOutput("morto_alerta_hold", 16'(bus_if.alerta), 16'h0);
    applyStimulus(3'b000, 8'd50, 8'd60, 8'd60, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 16'(bus_if.estado), 16'h0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Alert thresholds: strictly below 25.
    applyStimulus(3'b000, 8'd24, 8'd25, 8'd10, 1'b0);
    tick(1);
    checkOutput("alerta_101", 16'(bus_if.alerta), 16'h5);
    checkOutput("alerta_idle", 16'(bus_if.estado), 16'h0);
    applyStimulus(3'b000, 8'd24, 8'd20, 8'd10, 1'b0);
    tick(1);
    checkOutput("alerta_111", 16'(bus_if.alerta), 16'h7);
`ifdef CONTROLADOR_AUTO_SONO_EN
    checkOutput("auto_sono", 16'(bus_if.estado), 16'h1);
`else
    checkOutput("no_auto_sono", 16'(bus_if.estado), 16'h0);
`endif

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/controlador_estados.md
Name: controlador_estados

Overview:
- Pet behaviour FSM that produces the 3-bit `estado` code consumed by the attribute controller.
- Consumes the attribute controller's `fome`, `sono`, `felicidade` and `morreu` outputs.
- Converts player button presses into timed activities (sleep, eat, teach class) and ends them on attribute saturation, timeout or cancel.
- Enters a sticky dead state and raises per-attribute low-level alerts.

Parameters:
- MAX_ATRIBUTO, 100: attribute value at or above which the current activity ends.
- DURACAO_MAX, 1000: maximum activity length in clk cycles; 16-bit range.
- COOLDOWN, 50: cycles after leaving an activity during which new requests are ignored; 16-bit range.
- LIMIAR_ALERTA, 25: an alert bit is high while its attribute is strictly below this value.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_dormir  in  1  sleep button; level input, already synchronized and debounced upstream
- btn_comer  in  1  eat button; same conditioning as btn_dormir
- btn_aula  in  1  teach-class button; same conditioning as btn_dormir
- fome  in  8  hunger attribute
- sono  in  8  sleep attribute
- felicidade  in  8  happiness attribute
- morreu  in  1  death flag from the attribute controller
- estado  out  3  activity code to the attribute controller
- ocupado  out  1  high while in any activity state
- alerta  out  3  {fome, sono, felicidade} below LIMIAR_ALERTA

Behaviour:
- Encoding (fixed, shared with the attribute controller): OCIOSO=3'b000, DORMINDO=3'b001, COMENDO=3'b010, DANDO_AULA=3'b011, MORTO=3'b100.
- Reset (async assert, sync release): estado=OCIOSO, ocupado=0, alerta=0, activity timer=0, cooldown counter=0, button history registers=0.
- Edge detect: press = btn & ~btn_q, with btn_q registered each cycle. A held button produces exactly one press.
- Latency: the state change is visible after the clk edge at which the press is first sampled, i.e. 1 cycle.
- Priority, applied every cycle, highest first:
  1. morreu=1 -> MORTO.
  2. In an activity state, exit conditions.
  3. In OCIOSO, new requests.
- OCIOSO:
  - If cooldown=0 and a press occurs, go to the matching activity and clear the timer.
  - Simultaneous presses resolve as dormir > comer > aula.
  - While cooldown>0 all presses are discarded, not queued, and cooldown decrements by 1 per cycle.
- Activity states (DORMINDO/sono, COMENDO/fome, DANDO_AULA/felicidade):
  - The timer increments each cycle.
  - Return to OCIOSO and load cooldown=COOLDOWN when any of these holds:
    - the governing attribute >= MAX_ATRIBUTO;
    - timer == DURACAO_MAX-1;
    - the same activity's button is pressed again (cancel).
  - Presses of other buttons are ignored.
  - The timer saturates and never wraps.
- MORTO: absorbing. Buttons and attributes are ignored. Only rst_n leaves it. ocupado=0.
- ocupado is registered and equals (estado is DORMINDO, COMENDO or DANDO_AULA).
- alerta is registered each cycle from the inputs, giving 1-cycle latency, and holds its last value in MORTO.
- Comparisons are unsigned 8-bit. Attributes above 100 are legal and count as saturated.
- Reset mid-activity returns to OCIOSO immediately, with cooldown=0.

Optional Feature:
- Macro: CONTROLADOR_AUTO_SONO_EN.
- Defined:
  - In OCIOSO with cooldown=0 and no press, sono < LIMIAR_ALERTA forces DORMINDO (the pet falls asleep on its own).
  - An explicit press in the same cycle wins over the forced sleep.
- Undefined: no automatic transitions. The logic is absent from the netlist.

Decomposition:
- Package tamagotchi_pkg holds:
  - the estado encodings;
  - MAX_ATRIBUTO and LIMIAR_ALERTA defaults;
  - the attribute width (8).
- The package is shared with the attribute controller.
- One sub-module, detector_borda (a parameterizable N-bit rising-edge detector), instantiated once for the 3 buttons.
- Timer, cooldown and FSM stay in the top module.

Test Plan (bench parameters DURACAO_MAX=20, COOLDOWN=4, LIMIAR_ALERTA=25):
- Reset, then btn_comer high for 5 cycles with fome=50 -> estado=010 one cycle after the first sample, ocupado=1. Exactly one activity start is seen.
- DORMINDO with sono=60 held constant -> returns to 000 after 20 cycles. Presses during the following 4 cycles are ignored; a press on cycle 5 is accepted.
- COMENDO, then fome driven to 100 -> estado=000 on the next edge. A btn_aula press in COMENDO before that has no effect.
- btn_dormir, btn_comer and btn_aula pressed in the same cycle from OCIOSO -> estado=001. Pressing btn_dormir again cancels to 000.
- morreu=1 during DANDO_AULA -> estado=100. The state persists through presses and morreu returning to 0; after rst_n pulse low -> 000.
- fome=24, sono=25, felicidade=10 -> alerta=3'b101. With CONTROLADOR_AUTO_SONO_EN and sono=20 in OCIOSO -> estado=001 unprompted.
